pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 42 ++++
 rtl/pipeline_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall interface between the pipeline datapath and pipeline_ctrl.
// master: the controller side; slave: the datapath side.
interface pipeline_ctrl_if;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  ex_rd_addr;
  logic        ex_rf_wen;
  logic        ex_is_load;
  logic [4:0]  mem_rd_addr;
  logic        mem_rf_wen;
  logic        ex_br_taken;
  logic        dmem_req;
  logic        dmem_ack;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        pc_sel_br;
  logic [15:0] stall_cnt;
  logic        mem_timeout;

  modport master (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  ex_rd_addr, ex_rf_wen, ex_is_load, mem_rd_addr, mem_rf_wen,
    input  ex_br_taken, dmem_req, dmem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, pc_sel_br, stall_cnt, mem_timeout
  );

  modport slave (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output ex_rd_addr, ex_rf_wen, ex_is_load, mem_rd_addr, mem_rf_wen,
    output ex_br_taken, dmem_req, dmem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, pc_sel_br, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline stall/flush controller: boot sequencing, memory freeze, branch flush, data hazards.
// Optional macro FWD_EN: EX/MEM forwarding present, only load-use hazards stall.
module pipeline_ctrl #(
  parameter int unsigned MWAIT_MAX = 255
) (
  input logic             clk,
  input logic             rst,
  pipeline_ctrl_if.master bus
);

  localparam int unsigned WW = (MWAIT_MAX < 2) ? 1 : $clog2(MWAIT_MAX + 1);
  localparam logic [WW-1:0] WMAX = WW'(MWAIT_MAX);

  typedef enum logic [1:0] {BOOT, RUN, MWAIT} state_t;

  state_t        state_q, state_d;
  logic          boot_cnt_q, boot_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;
  logic          mem_timeout_q, mem_timeout_d;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, pc_sel_br;
  logic apply_run;
  logic ex_hit, mem_hit, hazard;

  function automatic logic src_match(input logic used, input logic [4:0] src,
                                     input logic wen, input logic [4:0] rd);
    return used && wen && (src != '0) && (src == rd);
  endfunction

  always_comb begin
    ex_hit  = src_match(bus.id_rs1_used, bus.id_rs1_addr, bus.ex_rf_wen, bus.ex_rd_addr)
            | src_match(bus.id_rs2_used, bus.id_rs2_addr, bus.ex_rf_wen, bus.ex_rd_addr);
    mem_hit = src_match(bus.id_rs1_used, bus.id_rs1_addr, bus.mem_rf_wen, bus.mem_rd_addr)
            | src_match(bus.id_rs2_used, bus.id_rs2_addr, bus.mem_rf_wen, bus.mem_rd_addr);
`ifdef FWD_EN
    hazard  = ex_hit & bus.ex_is_load;
`else
    hazard  = ex_hit | mem_hit;
`endif
  end

`ifdef FWD_EN
  logic unused_mem_hit;
  assign unused_mem_hit = mem_hit;
`else
  logic unused_is_load;
  assign unused_is_load = bus.ex_is_load;
`endif

  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    mem_timeout_d = mem_timeout_q;
    apply_run     = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    pc_sel_br     = 1'b0;

    unique case (state_q)
      BOOT: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (boot_cnt_q) begin
          boot_cnt_d = 1'b0;
          state_d    = RUN;
        end else begin
          boot_cnt_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ack) begin
          state_d    = MWAIT;
          wait_cnt_d = '0;
        end else begin
          apply_run = 1'b1;
        end
      end
      MWAIT: begin
        if (bus.dmem_ack) begin
          apply_run  = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          // Counter saturates at the limit; the FSM keeps waiting for ack.
          wait_cnt_d    = (wait_cnt_q == WMAX) ? WMAX : wait_cnt_q + 1'b1;
          mem_timeout_d = mem_timeout_q | (wait_cnt_d == WMAX);
        end
      end
      default: state_d = BOOT;
    endcase

    if (apply_run) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (bus.ex_br_taken) begin
        pc_sel_br   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hazard) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (state_q != BOOT && !pc_en && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;

    if (rst) begin
      state_d       = BOOT;
      boot_cnt_d    = 1'b0;
      wait_cnt_d    = '0;
      stall_cnt_d   = '0;
      mem_timeout_d = 1'b0;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      pc_sel_br     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    boot_cnt_q    <= boot_cnt_d;
    wait_cnt_q    <= wait_cnt_d;
    stall_cnt_q   <= stall_cnt_d;
    mem_timeout_q <= mem_timeout_d;
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.mem_wb_en   = mem_wb_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.pc_sel_br   = pc_sel_br;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.mem_timeout = mem_timeout_q;

endmodule
